// File: rtl/bip_pc_unit_if.sv
// bip_pc_unit_if: command/status bundle between the BIP control unit and the
// program-counter unit.
//
// Command signals (en, wr_pc, call, ret, address_bus) are level commands
// sampled on every rising clock edge. There is no valid/ready handshake. The
// PC unit accepts a command on every cycle and never stalls the driver. Results
// appear on the status signals one cycle later. All status signals come from
// registered state only.
//
// state_dbg exposes the encoded FSM state so that external checkers can bind
// to it.
interface bip_pc_unit_if #(
   parameter int AB    = 11,
   parameter int DEPTH = 4
);
   localparam int SPW = $clog2(DEPTH) + 1;

   // commands from the control unit
   logic          en;
   logic          wr_pc;
   logic          call;
   logic          ret;
   logic [AB-1:0] address_bus;

   // status from the PC unit
   logic [AB-1:0]  addr;
   logic [SPW-1:0] sp;
   logic           stack_full;
   logic           stack_empty;
   logic           fault;
   logic [1:0]     fault_code;
   logic           halted;
   logic [1:0]     state_dbg;

   // control-unit side
   modport master (
      output en, wr_pc, call, ret, address_bus,
      input  addr, sp, stack_full, stack_empty, fault, fault_code, halted,
             state_dbg
   );

   // program-counter side
   modport slave (
      input  en, wr_pc, call, ret, address_bus,
      output addr, sp, stack_full, stack_empty, fault, fault_code, halted,
             state_dbg
   );
endinterface

// File: rtl/bip_pc_unit.sv
// bip_pc_unit: program counter for the BIP datapath.
//
// The unit holds the fetch address and supports the following operations:
//   - increment on en;
//   - single-cycle jump on wr_pc;
//   - call/return through an internal return-address stack of DEPTH entries.
//
// Stack misuse freezes the unit in FAULT until reset. The fault cases are
// overflow, underflow, and call together with ret in the same cycle.
//
// Optional feature macro: PC_LIMIT_EN. When it is defined, an en at
// addr == LIMIT parks the unit in HALT. Only wr_pc, or a successful call or
// ret, leaves HALT.
//
// Command priority in each cycle: conflict > ret > call > wr_pc > en.
module bip_pc_unit #(
   parameter int          AB         = 11,
   parameter int          DEPTH      = 4,
   parameter logic [AB-1:0] RESET_ADDR = '0,
   parameter logic [AB-1:0] LIMIT      = {AB{1'b1}}
) (
   input logic          clk,
   input logic          reset,
   bip_pc_unit_if.slave pc
);

   localparam int SPW = $clog2(DEPTH) + 1;
   localparam int IW  = $clog2(DEPTH);
   localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

   localparam logic [1:0] CODE_NONE     = 2'b00;
   localparam logic [1:0] CODE_OVERFLOW = 2'b01;
   localparam logic [1:0] CODE_UNDERFLW = 2'b10;
   localparam logic [1:0] CODE_CONFLICT = 2'b11;

`ifdef PC_LIMIT_EN
   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_HALT  = 2'd1,
      S_FAULT = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_FAULT = 2'd2
   } state_t;
`endif

   state_t         state_q, state_d;
   logic [AB-1:0]  addr_q, addr_d;
   logic [SPW-1:0] sp_q, sp_d;
   logic [1:0]     code_q, code_d;

   // return-address storage; contents are don't-care after reset
   logic [AB-1:0]  stack_q [DEPTH];
   logic           push;
   logic [IW-1:0]  push_idx;
   logic [IW-1:0]  pop_idx;
   logic [AB-1:0]  addr_inc;

   assign addr_inc = addr_q + AB'(1);
   assign push_idx = sp_q[IW-1:0];
   assign pop_idx  = sp_q[IW-1:0] - IW'(1);

   // next-state decode: one winning command per cycle, FAULT absorbs everything
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      sp_d    = sp_q;
      code_d  = code_q;
      push    = 1'b0;
      if (state_q != S_FAULT) begin
         if (pc.call && pc.ret) begin
            state_d = S_FAULT;
            code_d  = CODE_CONFLICT;
         end else if (pc.ret) begin
            if (sp_q == '0) begin
               state_d = S_FAULT;
               code_d  = CODE_UNDERFLW;
            end else begin
               addr_d  = stack_q[pop_idx];
               sp_d    = sp_q - SPW'(1);
               state_d = S_RUN;
            end
         end else if (pc.call) begin
            if (sp_q == SP_FULL) begin
               state_d = S_FAULT;
               code_d  = CODE_OVERFLOW;
            end else begin
               push    = 1'b1;
               sp_d    = sp_q + SPW'(1);
               addr_d  = pc.address_bus;
               state_d = S_RUN;
            end
         end else if (pc.wr_pc) begin
            addr_d  = pc.address_bus;
            state_d = S_RUN;
         end else if (pc.en) begin
`ifdef PC_LIMIT_EN
            // en has no effect while halted; at LIMIT the address parks
            if (state_q == S_RUN) begin
               if (addr_q == LIMIT) begin
                  state_d = S_HALT;
               end else begin
                  addr_d = addr_inc;
               end
            end
`else
            addr_d = addr_inc;
`endif
         end
      end
   end

   // state, address, stack pointer and fault code registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_RUN;
         addr_q  <= RESET_ADDR;
         sp_q    <= '0;
         code_q  <= CODE_NONE;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         sp_q    <= sp_d;
         code_q  <= code_d;
      end
   end

   // stack write: the return address is the caller's addr+1, wrapped to AB bits
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         stack_q[push_idx] <= addr_inc;
      end
   end

   // status decoded purely from registered state
   assign pc.addr        = addr_q;
   assign pc.sp          = sp_q;
   assign pc.stack_full  = (sp_q == SP_FULL);
   assign pc.stack_empty = (sp_q == '0);
   assign pc.fault       = (state_q == S_FAULT);
   assign pc.fault_code  = code_q;
   assign pc.state_dbg   = state_q;
`ifdef PC_LIMIT_EN
   assign pc.halted      = (state_q == S_HALT);
`else
   assign pc.halted      = 1'b0;
`endif

endmodule

// File: tb/tb_bip_pc_unit.sv
// tb_bip_pc_unit: directed checks of the BIP program-counter unit.
//
// The optional limit scenario is compiled in only when PC_LIMIT_EN is defined.
module tb_bip_pc_unit;

   localparam int AB    = 11;
   localparam int DEPTH = 4;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   bip_pc_unit_if #(.AB(AB), .DEPTH(DEPTH)) pc_if ();

   bip_pc_unit #(
      .AB        (AB),
      .DEPTH     (DEPTH),
      .RESET_ADDR(11'd5),
      .LIMIT     (11'h020)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .pc   (pc_if.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // drive one command for one clock edge, then return to idle 1 time unit
   // after the edge, where outputs are sampled
   task automatic step(input logic e, input logic w, input logic c, input logic r,
                       input logic [AB-1:0] bus);
      pc_if.en          = e;
      pc_if.wr_pc       = w;
      pc_if.call        = c;
      pc_if.ret         = r;
      pc_if.address_bus = bus;
      @(posedge clk);
      #1;
      pc_if.en          = 1'b0;
      pc_if.wr_pc       = 1'b0;
      pc_if.call        = 1'b0;
      pc_if.ret         = 1'b0;
      pc_if.address_bus = '0;
   endtask

   task automatic do_reset(input logic w);
      reset       = 1'b1;
      pc_if.wr_pc = w;
      pc_if.address_bus = 11'h3AA;
      @(posedge clk);
      #1;
      reset       = 1'b0;
      pc_if.wr_pc = 1'b0;
      pc_if.address_bus = '0;
   endtask

   task automatic test_reset();
      logic [AB-1:0] exp_a;
      do_reset(1'b0);
      n_cmp++; if (pc_if.addr !== 11'd5) begin n_bad++; $display("FAIL reset_addr got %h want %h", pc_if.addr, 11'd5); end
      n_cmp++; if (pc_if.sp !== 3'd0) begin n_bad++; $display("FAIL reset_sp got %0d want 0", pc_if.sp); end
      n_cmp++; if (pc_if.stack_empty !== 1'b1 || pc_if.stack_full !== 1'b0) begin n_bad++; $display("FAIL reset_flags got e=%b f=%b want e=1 f=0", pc_if.stack_empty, pc_if.stack_full); end
      n_cmp++; if (pc_if.fault !== 1'b0 || pc_if.fault_code !== 2'b00 || pc_if.halted !== 1'b0) begin n_bad++; $display("FAIL reset_status got f=%b c=%b h=%b want 0 00 0", pc_if.fault, pc_if.fault_code, pc_if.halted); end
      exp_a = 11'd5;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, '0);
         exp_a = exp_a + 11'd1;
         n_cmp++; if (pc_if.addr !== exp_a) begin n_bad++; $display("FAIL en_inc[%0d] got %h want %h", i, pc_if.addr, exp_a); end
      end
      n_cmp++; if (pc_if.sp !== 3'd0 || pc_if.stack_empty !== 1'b1) begin n_bad++; $display("FAIL en_sp got sp=%0d e=%b want 0 1", pc_if.sp, pc_if.stack_empty); end
      // no command: address holds
      step(1'b0, 1'b0, 1'b0, 1'b0, 11'h155);
      n_cmp++; if (pc_if.addr !== 11'd8) begin n_bad++; $display("FAIL idle_hold got %h want %h", pc_if.addr, 11'd8); end
   endtask

   task automatic test_wrap();
      step(1'b0, 1'b1, 1'b0, 1'b0, 11'h7FF);
      n_cmp++; if (pc_if.addr !== 11'h7FF) begin n_bad++; $display("FAIL jump_7ff got %h want 7ff", pc_if.addr); end
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
`ifndef PC_LIMIT_EN
      n_cmp++; if (pc_if.addr !== 11'h000) begin n_bad++; $display("FAIL wrap got %h want 000", pc_if.addr); end
`endif
      // wr_pc beats en in the same cycle
      step(1'b1, 1'b1, 1'b0, 1'b0, 11'h010);
      n_cmp++; if (pc_if.addr !== 11'h010) begin n_bad++; $display("FAIL jump_prio got %h want 010", pc_if.addr); end
   endtask

   task automatic test_call_ret();
      logic [AB-1:0] tgt [4];
      logic [AB-1:0] rets [4];
      tgt[0] = 11'h100; tgt[1] = 11'h200; tgt[2] = 11'h300; tgt[3] = 11'h400;
      rets[0] = 11'h301; rets[1] = 11'h201; rets[2] = 11'h101; rets[3] = 11'h011;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 1'b1, 1'b0, tgt[i]);
         n_cmp++; if (pc_if.addr !== tgt[i] || pc_if.sp !== 3'(i + 1)) begin n_bad++; $display("FAIL call[%0d] got a=%h sp=%0d want a=%h sp=%0d", i, pc_if.addr, pc_if.sp, tgt[i], i + 1); end
      end
      n_cmp++; if (pc_if.stack_full !== 1'b1 || pc_if.stack_empty !== 1'b0) begin n_bad++; $display("FAIL full_flag got f=%b e=%b want 1 0", pc_if.stack_full, pc_if.stack_empty); end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b1, 11'h7AA);
         n_cmp++; if (pc_if.addr !== rets[i] || pc_if.sp !== 3'(3 - i)) begin n_bad++; $display("FAIL ret[%0d] got a=%h sp=%0d want a=%h sp=%0d", i, pc_if.addr, pc_if.sp, rets[i], 3 - i); end
      end
      n_cmp++; if (pc_if.stack_empty !== 1'b1 || pc_if.fault !== 1'b0) begin n_bad++; $display("FAIL empty_after_ret got e=%b f=%b want 1 0", pc_if.stack_empty, pc_if.fault); end
   endtask

   task automatic test_back_to_back();
      // addr is 0x011 here; call to 0x123 pushes 0x012, the very next ret pops it
      step(1'b0, 1'b0, 1'b1, 1'b0, 11'h123);
      n_cmp++; if (pc_if.addr !== 11'h123) begin n_bad++; $display("FAIL b2b_call got %h want 123", pc_if.addr); end
      step(1'b0, 1'b0, 1'b0, 1'b1, '0);
      n_cmp++; if (pc_if.addr !== 11'h012 || pc_if.sp !== 3'd0) begin n_bad++; $display("FAIL b2b_ret got a=%h sp=%0d want 012 0", pc_if.addr, pc_if.sp); end
      // call from the top address pushes a wrapped 0x000
      step(1'b0, 1'b1, 1'b0, 1'b0, 11'h7FF);
      step(1'b0, 1'b0, 1'b1, 1'b0, 11'h044);
      step(1'b0, 1'b0, 1'b0, 1'b1, '0);
      n_cmp++; if (pc_if.addr !== 11'h000) begin n_bad++; $display("FAIL push_wrap got %h want 000", pc_if.addr); end
   endtask

   task automatic test_overflow();
      step(1'b0, 1'b1, 1'b0, 1'b0, 11'h050);
      step(1'b0, 1'b0, 1'b1, 1'b0, 11'h100);
      step(1'b0, 1'b0, 1'b1, 1'b0, 11'h200);
      step(1'b0, 1'b0, 1'b1, 1'b0, 11'h300);
      step(1'b0, 1'b0, 1'b1, 1'b0, 11'h400);
      step(1'b0, 1'b0, 1'b1, 1'b0, 11'h500);
      n_cmp++; if (pc_if.fault !== 1'b1 || pc_if.fault_code !== 2'b01) begin n_bad++; $display("FAIL ovf_code got f=%b c=%b want 1 01", pc_if.fault, pc_if.fault_code); end
      n_cmp++; if (pc_if.addr !== 11'h400 || pc_if.sp !== 3'd4) begin n_bad++; $display("FAIL ovf_frozen got a=%h sp=%0d want 400 4", pc_if.addr, pc_if.sp); end
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 11'h111);
      step(1'b0, 1'b0, 1'b0, 1'b1, '0);
      n_cmp++; if (pc_if.addr !== 11'h400 || pc_if.sp !== 3'd4 || pc_if.fault_code !== 2'b01) begin n_bad++; $display("FAIL fault_ignores got a=%h sp=%0d c=%b want 400 4 01", pc_if.addr, pc_if.sp, pc_if.fault_code); end
      do_reset(1'b1);
      n_cmp++; if (pc_if.addr !== 11'd5 || pc_if.fault !== 1'b0 || pc_if.sp !== 3'd0 || pc_if.fault_code !== 2'b00) begin n_bad++; $display("FAIL fault_reset got a=%h f=%b sp=%0d c=%b want 005 0 0 00", pc_if.addr, pc_if.fault, pc_if.sp, pc_if.fault_code); end
   endtask

   task automatic test_underflow_conflict();
      step(1'b1, 1'b0, 1'b0, 1'b1, '0);
      n_cmp++; if (pc_if.fault !== 1'b1 || pc_if.fault_code !== 2'b10 || pc_if.addr !== 11'd5) begin n_bad++; $display("FAIL underflow got f=%b c=%b a=%h want 1 10 005", pc_if.fault, pc_if.fault_code, pc_if.addr); end
      do_reset(1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 11'h080);
      step(1'b1, 1'b1, 1'b1, 1'b1, 11'h090);
      n_cmp++; if (pc_if.fault_code !== 2'b11 || pc_if.sp !== 3'd1 || pc_if.addr !== 11'h080) begin n_bad++; $display("FAIL conflict got c=%b sp=%0d a=%h want 11 1 080", pc_if.fault_code, pc_if.sp, pc_if.addr); end
      do_reset(1'b0);
   endtask

`ifdef PC_LIMIT_EN
   task automatic test_limit();
      step(1'b0, 1'b1, 1'b0, 1'b0, 11'h01F);
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      n_cmp++; if (pc_if.addr !== 11'h020 || pc_if.halted !== 1'b0) begin n_bad++; $display("FAIL lim_reach got a=%h h=%b want 020 0", pc_if.addr, pc_if.halted); end
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      n_cmp++; if (pc_if.addr !== 11'h020 || pc_if.halted !== 1'b1) begin n_bad++; $display("FAIL lim_halt got a=%h h=%b want 020 1", pc_if.addr, pc_if.halted); end
      step(1'b1, 1'b0, 1'b0, 1'b0, '0);
      n_cmp++; if (pc_if.addr !== 11'h020 || pc_if.halted !== 1'b1) begin n_bad++; $display("FAIL lim_hold got a=%h h=%b want 020 1", pc_if.addr, pc_if.halted); end
      step(1'b0, 1'b1, 1'b0, 1'b0, 11'h030);
      n_cmp++; if (pc_if.addr !== 11'h030 || pc_if.halted !== 1'b0) begin n_bad++; $display("FAIL lim_resume got a=%h h=%b want 030 0", pc_if.addr, pc_if.halted); end
      do_reset(1'b0);
   endtask
`endif

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      pc_if.en = 1'b0;
      pc_if.wr_pc = 1'b0;
      pc_if.call = 1'b0;
      pc_if.ret = 1'b0;
      pc_if.address_bus = '0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_wrap();
      test_call_ret();
      test_back_to_back();
      test_overflow();
      test_underflow_conflict();
`ifdef PC_LIMIT_EN
      test_limit();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
